mic1_mem_initiator: RTL
=======================

Name: mic1_mem_initiator

Overview:
- Initiator side of the MIC-1 dual-port main memory.
- Owns the datapath memory registers: MAR (word address), MDR, PC (byte address) and MBR.
- Turns the microinstruction rd, wr and fetch strobes into port A word read/write cycles and port B byte-fetch cycles.
- Captures returned data with the memory's fixed 1-cycle registered read latency and presents it to the datapath.

Parameters:
- DATA_W, 32, width of MAR/MDR/PC, C bus and memory data.
- MEM_WORDS, 512, number of implemented memory words; used for the address-range check.

Ports:
- clk  in  1  single clock; all state updates on the posedge.
- rst  in  1  synchronous, active-high reset.
- c_bus  in  32  datapath C bus.
- ld_mar / ld_mdr / ld_pc  in  1 each  load the register from c_bus at the edge.
- rd, wr, fetch  in  1 each  memory-operation strobes, one cycle each.
- mar, mdr, pc  out  32 each  register values.
- mbr  out  8  fetched byte.
- mbr_sext, mbr_zext  out  32 each  sign- and zero-extended MBR.
- rd_pending, fetch_pending  out  1 each  capture scheduled at the next edge.
- protocol_err  out  1  one-cycle pulse on an illegal combination.
- err_sticky  out  1  OR of all past protocol_err and address errors; cleared only by rst.
- wen_A, ren_A, ren_B  out  1 each  memory strobes.
- addr_A, wdata_A, addr_B  out  32 each  memory address and write data.
- rdata_A  in  32  memory port A read data.
- rdata_B  in  8  memory port B byte; selected inside the memory by addr_B[1:0].

Behaviour:
- Reset:
  - mar, mdr, pc, mbr, both pending flags and err_sticky are 0.
  - All memory strobes are 0; protocol_err is 0.
  - Reset during a pending read or fetch cancels the capture; MDR/MBR stay 0.
- Port A read, rd in cycle k:
  - ren_A=1 and addr_A=mar (registered value at the start of k).
  - rd_pending=1 during k+1.
  - At the end of k+1, mdr <= rdata_A. The new mdr is visible in k+2.
- Port A write, wr in cycle k:
  - wen_A=1, addr_A=mar, wdata_A=mdr.
  - The memory updates at the end of k.
- Back-to-back reads (rd in k and k+1) are legal and pipelined; each read captures in its own following cycle.
- ld_mar or ld_mdr in the issue cycle k takes effect at the end of k. The issued operation uses the pre-edge values.
- rd together with wr:
  - wr wins and rd is dropped; protocol_err pulses.
  - Exception: if mar changes via ld_mar in the same cycle, the write still uses the old mar.
- ld_mdr in a capture cycle (rd_pending=1): read data wins, ld_mdr is ignored, protocol_err pulses.
- Fetch, fetch in cycle k:
  - ren_B=1 and addr_B=pc.
  - A fetch_addr register latches pc at the end of k.
  - During k+1, addr_B is driven from fetch_addr, not the live pc. This keeps the memory's byte select stable even when ld_pc fires.
  - At the end of k+1, mbr <= rdata_B.
- Idle: addr_B holds fetch_addr; ren_B=0.
- fetch while fetch_pending=1:
  - The fetch is ignored: no ren_B, no change to fetch_addr.
  - protocol_err pulses.
  - Fetches therefore need at least 2 cycles between them.
- Reads/writes and fetches are independent and may coincide in the same cycle.
- MBR extension: mbr_sext = {{24{mbr[7]}}, mbr}; mbr_zext = {24'b0, mbr}.
- Address range check:
  - Checked for a rd or wr with mar >= MEM_WORDS, and for a fetch with (pc>>2) >= MEM_WORDS.
  - The operation is still issued.
  - err_sticky sets at the edge; protocol_err does not pulse.
- Idle memory outputs: addr_A=mar and wdata_A=mdr continuously; wen_A=ren_A=0 unless issuing.

Decomposition:
- Package mic1_mem_pkg holds:
  - READ_LATENCY=1
  - BYTE_SEL_W=2
  - DATA_W default
  - mem_op_t enum {OP_NONE, OP_RD, OP_WR}, the resolved port A operation
- Single module; no sub-module is warranted.
- The bench reuses the existing main memory model as the responder.

Test Plan:
- Write then read:
  - Cycle 0: ld_mar with c_bus=5. Cycle 1: ld_mdr with 0xDEADBEEF.
  - Cycle 2: wr. Cycle 3: ld_mdr=0. Cycle 4: rd.
  - Required: mdr=0xDEADBEEF in cycle 6; wen_A high only in cycle 2, with addr_A=5.
- Byte fetch with PC change:
  - Word 1 = 0x44332211; pc=6; fetch in cycle k; ld_pc=7 in k as well.
  - Required: addr_B=6 in k+1, mbr=0x33 in k+2, mbr_sext=0x00000033.
- Sign and zero extension:
  - Fetch a byte of value 0x80.
  - Required: mbr_sext=0xFFFFFF80, mbr_zext=0x00000080.
- Back-to-back reads:
  - mar=0 in k; ld_mar=1 in k; rd in k and k+1.
  - Required: mdr=mem[0] in k+2, mdr=mem[1] in k+3; no protocol_err.
- Conflicts:
  - rd+wr in the same cycle: wen_A=1, ren_A=0, protocol_err pulses once.
  - Fetch in two consecutive cycles: the second fetch has no ren_B; protocol_err=1 and err_sticky=1.
- Reset mid-operation:
  - rd in k, rst in k+1.
  - Required: mdr=0 in k+2, rd_pending=0, err_sticky=0.

Source files
------------

// File: rtl/mic1_mem_pkg.sv
// Shared constants and types for the MIC-1 main-memory initiator.
package mic1_mem_pkg;

    localparam int READ_LATENCY = 1;
    localparam int BYTE_SEL_W   = 2;
    localparam int DATA_W       = 32;

    // Port A operation after rd/wr conflict resolution.
    typedef enum logic [1:0] {
        OP_NONE,
        OP_RD,
        OP_WR
    } mem_op_t;

endpackage

// File: rtl/mic1_mem_initiator.sv
// MIC-1 memory initiator: owns MAR/MDR/PC/MBR and drives the dual-port memory
// (port A word read/write, port B byte fetch) with 1-cycle registered read data.
module mic1_mem_initiator
    import mic1_mem_pkg::*;
#(
    parameter int DATA_W    = mic1_mem_pkg::DATA_W,
    parameter int MEM_WORDS = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] c_bus,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic              ld_pc,
    input  logic              rd,
    input  logic              wr,
    input  logic              fetch,
    output logic [DATA_W-1:0] mar,
    output logic [DATA_W-1:0] mdr,
    output logic [DATA_W-1:0] pc,
    output logic [7:0]        mbr,
    output logic [DATA_W-1:0] mbr_sext,
    output logic [DATA_W-1:0] mbr_zext,
    output logic              rd_pending,
    output logic              fetch_pending,
    output logic              protocol_err,
    output logic              err_sticky,
    output logic              wen_A,
    output logic              ren_A,
    output logic              ren_B,
    output logic [DATA_W-1:0] addr_A,
    output logic [DATA_W-1:0] wdata_A,
    output logic [DATA_W-1:0] addr_B,
    input  logic [DATA_W-1:0] rdata_A,
    input  logic [7:0]        rdata_B
);

    localparam logic [DATA_W-1:0] MEM_WORDS_W = DATA_W'(MEM_WORDS);

    logic [DATA_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [7:0]        mbr_q, mbr_d;
    logic              rd_pending_q, rd_pending_d;
    logic              fetch_pending_q, fetch_pending_d;
    logic              err_sticky_q, err_sticky_d;

    mem_op_t op;
    logic    issue_fetch;
    logic    perr;
    logic    addr_err;

    // Strobe decode; everything is held quiet while reset is asserted.
    always_comb begin
        op = OP_NONE;
        if (!rst) begin
            if (wr) begin
                op = OP_WR;
            end else if (rd) begin
                op = OP_RD;
            end
        end
        issue_fetch = !rst && fetch && !fetch_pending_q;
        perr = !rst && ((rd && wr) ||
                        (ld_mdr && rd_pending_q) ||
                        (fetch && fetch_pending_q));
        addr_err = ((op != OP_NONE) && (mar_q >= MEM_WORDS_W)) ||
                   (issue_fetch && ((pc_q >> BYTE_SEL_W) >= MEM_WORDS_W));
    end

    always_comb begin
        mar_d           = ld_mar ? c_bus : mar_q;
        pc_d            = ld_pc ? c_bus : pc_q;
        mdr_d           = mdr_q;
        // Returning read data has priority over a datapath load of MDR.
        if (rd_pending_q) begin
            mdr_d = rdata_A;
        end else if (ld_mdr) begin
            mdr_d = c_bus;
        end
        mbr_d           = fetch_pending_q ? rdata_B : mbr_q;
        rd_pending_d    = (op == OP_RD);
        fetch_pending_d = issue_fetch;
        fetch_addr_d    = issue_fetch ? pc_q : fetch_addr_q;
        err_sticky_d    = err_sticky_q || perr || addr_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mar_q           <= '0;
            mdr_q           <= '0;
            pc_q            <= '0;
            fetch_addr_q    <= '0;
            mbr_q           <= '0;
            rd_pending_q    <= 1'b0;
            fetch_pending_q <= 1'b0;
            err_sticky_q    <= 1'b0;
        end else begin
            mar_q           <= mar_d;
            mdr_q           <= mdr_d;
            pc_q            <= pc_d;
            fetch_addr_q    <= fetch_addr_d;
            mbr_q           <= mbr_d;
            rd_pending_q    <= rd_pending_d;
            fetch_pending_q <= fetch_pending_d;
            err_sticky_q    <= err_sticky_d;
        end
    end

    assign mar           = mar_q;
    assign mdr           = mdr_q;
    assign pc            = pc_q;
    assign mbr           = mbr_q;
    assign mbr_sext      = {{(DATA_W-8){mbr_q[7]}}, mbr_q};
    assign mbr_zext      = {{(DATA_W-8){1'b0}}, mbr_q};
    assign rd_pending    = rd_pending_q;
    assign fetch_pending = fetch_pending_q;
    assign protocol_err  = perr;
    assign err_sticky    = err_sticky_q;

    assign wen_A   = (op == OP_WR);
    assign ren_A   = (op == OP_RD);
    assign ren_B   = issue_fetch;
    assign addr_A  = mar_q;
    assign wdata_A = mdr_q;
    // Outside the issue cycle the latched fetch address keeps the byte select stable.
    assign addr_B  = issue_fetch ? pc_q : fetch_addr_q;

endmodule
